// File: rtl/blink_rate_sequencer_if.sv
// Signal bundle between the blink-rate sequencer and its environment:
// button/stop/mode/select inputs in, rate-select/enable/status out.
interface blink_rate_sequencer_if;
    logic       i_button;
    logic       i_stop;
    logic       i_mode_auto;
    logic [1:0] i_manual_sel;
    logic       o_switch_1;
    logic       o_switch_2;
    logic       o_enable;
    logic [1:0] o_step;
    logic       o_busy;

    // Environment side: drives the controls, observes the blinker drive.
    modport master (
        output i_button, i_stop, i_mode_auto, i_manual_sel,
        input  o_switch_1, o_switch_2, o_enable, o_step, o_busy
    );

    // Sequencer side.
    modport slave (
        input  i_button, i_stop, i_mode_auto, i_manual_sel,
        output o_switch_1, o_switch_2, o_enable, o_step, o_busy
    );
endinterface

// File: rtl/blink_rate_sequencer.sv
// Rate sequencer for the four-rate LED blinker. A debounced push-button
// starts, pauses and resumes blinking; in auto mode the rate steps through
// the four codes on a fixed dwell, in manual mode it follows i_manual_sel.
module blink_rate_sequencer #(
    parameter int c_DEBOUNCE_CNT = 250,
    parameter int c_DWELL_CNT    = 25000
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    blink_rate_sequencer_if.slave bus
);

    localparam int c_DB_W = (c_DEBOUNCE_CNT > 1) ? $clog2(c_DEBOUNCE_CNT) : 1;
    localparam int c_DW_W = (c_DWELL_CNT > 1) ? $clog2(c_DWELL_CNT) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(c_DEBOUNCE_CNT - 1);
    localparam logic [c_DW_W-1:0] c_DW_LAST = c_DW_W'(c_DWELL_CNT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // Button path
    logic              sync_1;
    logic              sync_2;
    logic [c_DB_W-1:0] db_cnt;
    logic              db_level;
    logic              db_level_q;
    logic              press;

    // Sequencer state
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [c_DW_W-1:0] dwell;
    logic [c_DW_W-1:0] dwell_nxt;
    logic [1:0]        step;
    logic [1:0]        step_nxt;

    // Registered outputs
    logic [1:0]        sw;
    logic [1:0]        sw_nxt;
    logic              enable;
    logic              busy;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= bus.i_button;
            sync_2 <= sync_1;
        end
    end

    // Debounce: the level only follows the synced input after it has
    // disagreed for c_DEBOUNCE_CNT consecutive cycles.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync_2 != db_level) begin
            if (db_cnt == c_DB_LAST) begin
                db_level <= sync_2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + c_DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // One-cycle press pulse on the rising edge of the debounced level only.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            db_level_q <= 1'b0;
            press      <= 1'b0;
        end else begin
            db_level_q <= db_level;
            press      <= db_level & ~db_level_q;
        end
    end

    // Next state, step and dwell. Stop beats press; press beats the dwell
    // terminal count, so a pause never advances the step.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        dwell_nxt = dwell;
        if (bus.i_stop) begin
            state_nxt = S_IDLE;
            step_nxt  = 2'd0;
            dwell_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (press) begin
                        state_nxt = S_RUN;
                        step_nxt  = 2'd0;
                        dwell_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (press) begin
                        state_nxt = S_PAUSE;
                    end else if (bus.i_mode_auto) begin
                        if (dwell == c_DW_LAST) begin
                            dwell_nxt = '0;
                            step_nxt  = step + 2'd1;
                        end else begin
                            dwell_nxt = dwell + c_DW_W'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (press) begin
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    step_nxt  = 2'd0;
                    dwell_nxt = '0;
                end
            endcase
        end
        // Manual mode parks the dwell so a return to auto starts a full step.
        if (!bus.i_mode_auto) begin
            dwell_nxt = '0;
        end
    end

    // Rate code to the blinker: zero when idle, frozen while paused.
    always_comb begin
        sw_nxt = sw;
        case (state_nxt)
            S_RUN:   sw_nxt = bus.i_mode_auto ? step_nxt : bus.i_manual_sel;
            S_PAUSE: sw_nxt = sw;
            default: sw_nxt = 2'b00;
        endcase
    end

    // State, counters and outputs all update on the same edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_IDLE;
            step   <= 2'd0;
            dwell  <= '0;
            sw     <= 2'b00;
            enable <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            dwell  <= dwell_nxt;
            sw     <= sw_nxt;
            enable <= (state_nxt == S_RUN);
            busy   <= (state_nxt != S_IDLE);
        end
    end

    assign bus.o_switch_1 = sw[1];
    assign bus.o_switch_2 = sw[0];
    assign bus.o_enable   = enable;
    assign bus.o_step     = step;
    assign bus.o_busy     = busy;

endmodule

// File: tb/tb_blink_rate_sequencer.sv
// Bench for blink_rate_sequencer: hand-derived vector table for the main
// scenarios, explicit glitch and async-reset sequences, then randomized
// stimulus against an event-level reference model.
module tb_blink_rate_sequencer;

    localparam int DEB   = 4;
    localparam int DWELL = 8;

    logic i_clock;
    logic i_reset_n;
    blink_rate_sequencer_if bus();

    blink_rate_sequencer #(
        .c_DEBOUNCE_CNT(DEB),
        .c_DWELL_CNT   (DWELL)
    ) dut (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .bus      (bus.slave)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mst_t;
    int   m_s1, m_s2, m_deb, m_run;
    int   press_q[$];
    mst_t m_st;
    int   m_step, m_dwell, m_sw;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
        press_q = {0, 0};
        m_st = M_IDLE; m_step = 0; m_dwell = 0; m_sw = 0;
    endtask

    // One clock edge. A debounced rise becomes visible to the sequencer
    // two edges later (pulse register, then the state change).
    task automatic model_edge();
        int p;
        int rose;
        if (!i_reset_n) begin
            model_reset();
            return;
        end
        p    = press_q.pop_front();
        rose = 0;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = m_s2;
                m_run = 0;
                rose  = m_deb;
            end
        end else begin
            m_run = 0;
        end
        press_q.push_back(rose);
        m_s2 = m_s1;
        m_s1 = int'(bus.i_button);

        if (bus.i_stop) begin
            m_st = M_IDLE; m_step = 0; m_dwell = 0;
        end else if (p != 0) begin
            if (m_st == M_IDLE) begin
                m_st = M_RUN; m_step = 0; m_dwell = 0;
            end else if (m_st == M_RUN) begin
                m_st = M_PAUSE;
            end else begin
                m_st = M_RUN;
            end
        end else if (m_st == M_RUN && bus.i_mode_auto) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dwell = 0;
                m_step  = (m_step + 1) % 4;
            end
        end
        if (!bus.i_mode_auto) m_dwell = 0;

        case (m_st)
            M_IDLE:  m_sw = 0;
            M_RUN:   m_sw = bus.i_mode_auto ? m_step : int'(bus.i_manual_sel);
            default: ;
        endcase
    endtask

    function automatic int model_out();
        int en, bz;
        en = (m_st == M_RUN) ? 1 : 0;
        bz = (m_st != M_IDLE) ? 1 : 0;
        return (m_sw << 4) | (en << 3) | (m_step << 1) | bz;
    endfunction

    function automatic int dut_out();
        return int'({bus.o_switch_1, bus.o_switch_2, bus.o_enable, bus.o_step, bus.o_busy});
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge i_clock);
        model_edge();
        #1;
    endtask

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(string nm, int en, int bz, int sw, int st);
        check({nm, ".en"},   int'(bus.o_enable), en);
        check({nm, ".busy"}, int'(bus.o_busy), bz);
        check({nm, ".sw"},   int'({bus.o_switch_1, bus.o_switch_2}), sw);
        check({nm, ".step"}, int'(bus.o_step), st);
    endtask

    typedef struct {
        logic       btn;
        logic       stop;
        logic       auto_m;
        logic [1:0] sel;
        int         ncyc;
        int         en;
        int         busy;
        int         sw;
        int         step;
    } vec_t;

    function automatic vec_t mkv(logic b, logic s, logic a, logic [1:0] sl, int n,
                                 int en, int bz, int sw, int st);
        vec_t v;
        v.btn = b; v.stop = s; v.auto_m = a; v.sel = sl; v.ncyc = n;
        v.en = en; v.busy = bz; v.sw = sw; v.step = st;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   hold;

        //       btn stop auto sel  n    en bz sw st
        tbl.push_back(mkv(0, 0, 1, 2'b00, 3,  0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 1, 2'b00, 7,  0, 0, 0, 0)); // one edge short of RUN
        tbl.push_back(mkv(1, 0, 1, 2'b00, 1,  1, 1, 0, 0)); // RUN, step 0
        tbl.push_back(mkv(1, 0, 1, 2'b00, 2,  1, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 1, 2'b00, 5,  1, 1, 0, 0)); // dwell 7
        tbl.push_back(mkv(0, 0, 1, 2'b00, 1,  1, 1, 1, 1)); // 8 cycles -> step 1
        tbl.push_back(mkv(0, 0, 1, 2'b00, 6,  1, 1, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 2'b00, 2,  1, 1, 2, 2)); // step 2
        tbl.push_back(mkv(1, 0, 1, 2'b00, 5,  1, 1, 2, 2)); // dwell 5
        tbl.push_back(mkv(1, 0, 1, 2'b00, 1,  0, 1, 2, 2)); // PAUSE, step held
        tbl.push_back(mkv(0, 0, 1, 2'b00, 10, 0, 1, 2, 2));
        tbl.push_back(mkv(1, 0, 1, 2'b00, 8,  1, 1, 2, 2)); // resume at dwell 5
        tbl.push_back(mkv(1, 0, 1, 2'b00, 2,  1, 1, 2, 2));
        tbl.push_back(mkv(0, 0, 1, 2'b00, 1,  1, 1, 3, 3)); // advances 3 cycles later
        tbl.push_back(mkv(0, 0, 0, 2'b10, 1,  1, 1, 2, 3)); // manual sel 10
        tbl.push_back(mkv(0, 0, 0, 2'b10, 50, 1, 1, 2, 3)); // step frozen
        tbl.push_back(mkv(0, 0, 1, 2'b10, 7,  1, 1, 3, 3)); // back to auto, dwell from 0
        tbl.push_back(mkv(0, 0, 1, 2'b10, 1,  1, 1, 0, 0)); // 3 -> 0 wrap
        tbl.push_back(mkv(1, 0, 1, 2'b00, 8,  0, 1, 0, 0)); // press at terminal: PAUSE wins
        tbl.push_back(mkv(0, 0, 1, 2'b00, 10, 0, 1, 0, 0));
        tbl.push_back(mkv(1, 0, 1, 2'b00, 8,  1, 1, 0, 0)); // resume, dwell 7
        tbl.push_back(mkv(0, 0, 1, 2'b00, 1,  1, 1, 1, 1));
        tbl.push_back(mkv(0, 0, 1, 2'b00, 6,  1, 1, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 2'b00, 8,  0, 1, 2, 2)); // PAUSE at step 2
        tbl.push_back(mkv(0, 0, 1, 2'b00, 10, 0, 1, 2, 2));
        tbl.push_back(mkv(1, 0, 1, 2'b00, 7,  0, 1, 2, 2)); // press pulse now pending
        tbl.push_back(mkv(1, 1, 1, 2'b00, 1,  0, 0, 0, 0)); // stop beats press
        tbl.push_back(mkv(1, 0, 1, 2'b00, 5,  0, 0, 0, 0)); // held button: no new press

        // Reset state
        i_reset_n        = 1'b0;
        bus.i_button     = 1'b0;
        bus.i_stop       = 1'b0;
        bus.i_mode_auto  = 1'b1;
        bus.i_manual_sel = 2'b00;
        model_reset();
        repeat (3) tick();
        check_all("reset", 0, 0, 0, 0);
        i_reset_n = 1'b1;

        // Vector table
        foreach (tbl[k]) begin
            bus.i_button     = tbl[k].btn;
            bus.i_stop       = tbl[k].stop;
            bus.i_mode_auto  = tbl[k].auto_m;
            bus.i_manual_sel = tbl[k].sel;
            repeat (tbl[k].ncyc) tick();
            check_all($sformatf("vec%0d", k), tbl[k].en, tbl[k].busy, tbl[k].sw, tbl[k].step);
        end

        // Short bounces never make a press
        bus.i_button = 1'b0;
        bus.i_stop   = 1'b0;
        repeat (10) tick();
        for (int p = 0; p < 12; p++) begin
            bus.i_button = 1'b1;
            for (int c = 0; c < (p % 3) + 1; c++) begin
                tick();
                check("glitch.en", int'(bus.o_enable), 0);
                check("glitch.busy", int'(bus.o_busy), 0);
            end
            bus.i_button = 1'b0;
            repeat (2) begin
                tick();
                check("glitch.en", int'(bus.o_enable), 0);
                check("glitch.busy", int'(bus.o_busy), 0);
            end
        end
        repeat (8) tick();
        check_all("glitch.end", 0, 0, 0, 0);

        // Asynchronous reset in the middle of RUN
        bus.i_button = 1'b1;
        repeat (10) tick();
        check("prerst.en", int'(bus.o_enable), 1);
        check("prerst.busy", int'(bus.o_busy), 1);
        #3;
        i_reset_n    = 1'b0;
        bus.i_button = 1'b0;
        model_reset();
        #1;
        check_all("asyncrst", 0, 0, 0, 0);
        tick();
        i_reset_n = 1'b1;
        repeat (12) tick();
        check_all("postrst", 0, 0, 0, 0);

        // Randomized stimulus against the model
        i_reset_n = 1'b0;
        bus.i_button = 1'b0;
        bus.i_stop   = 1'b0;
        bus.i_mode_auto = 1'b1;
        tick();
        i_reset_n = 1'b1;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            check($sformatf("rand@%0d", i), dut_out(), model_out());
            if (hold == 0) begin
                bus.i_button = ~bus.i_button;
                hold = $urandom_range(1, 14);
            end
            hold--;
            bus.i_stop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 79) == 0) bus.i_mode_auto = ~bus.i_mode_auto;
            if ($urandom_range(0, 19) == 0) bus.i_manual_sel = 2'($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
